// File: rtl/masked_rand_source_pkg.sv
// Shared definitions for the masked randomness source: LFSR geometry,
// feedback taps, controller state encoding and the share-pair count helper.
package masked_rand_source_pkg;

    localparam int LFSR_WIDTH = 64;

    // Feedback taps at bits 63, 62, 60 and 59.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        RS_IDLE   = 2'd0,
        RS_WARMUP = 2'd1,
        RS_RUN    = 2'd2
    } rand_state_t;

    // Number of share pairs (i<j) an HPC3 multiplier needs fresh randomness for.
    function automatic int num_quad(input int num_shares);
        return (num_shares * (num_shares - 1)) / 2;
    endfunction

endpackage

// File: rtl/masked_rand_source_lfsr_unrolled.sv
// Combinational unrolling of the 64-bit Fibonacci LFSR: applies STEPS
// single-bit shifts in one cycle, so STEPS fresh bits enter the low end.
module lfsr_unrolled
    import masked_rand_source_pkg::*;
#(
    parameter int STEPS = 4
) (
    input  logic [LFSR_WIDTH-1:0] in_state,
    output logic [LFSR_WIDTH-1:0] out_state
);

    // Chain STEPS shifts; each new bit is the parity of the tapped bits.
    always_comb begin
        logic [LFSR_WIDTH-1:0] st;
        st = in_state;
        for (int i = 0; i < STEPS; i++) begin
            st = {st[LFSR_WIDTH-2:0], ^(st & LFSR_TAPS)};
        end
        out_state = st;
    end

endmodule

// File: rtl/masked_rand_source.sv
// Fresh-randomness supplier for NUM_MULS masked HPC3 multipliers.
// Seed handshake loads the LFSR, a warm-up phase discards WARMUP_CYCLES
// cycle-steps, then one fresh OUT_BITS word is streamed per accepted transfer.
// Optional zero-state health checker: define RAND_SOURCE_HEALTH_EN.
module masked_rand_source
    import masked_rand_source_pkg::*;
#(
    parameter int NUM_SHARES    = 2,
    parameter int BIT_WIDTH     = 2,
    parameter int NUM_MULS      = 1,
    parameter int WARMUP_CYCLES = 16,
    localparam int NUM_QUAD     = num_quad(NUM_SHARES),
    localparam int OUT_BITS     = 2 * NUM_MULS * NUM_QUAD * BIT_WIDTH,
    localparam int HALF         = OUT_BITS / 2
) (
    input  logic                  in_clock,
    input  logic                  in_reset,
    input  logic [LFSR_WIDTH-1:0] in_seed,
    input  logic                  in_seed_valid,
    output logic                  out_seed_ready,
    output logic [HALF-1:0]       out_r,
    output logic [HALF-1:0]       out_p,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic                  out_error
);

    localparam int CW = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES + 1);

    generate
        if (OUT_BITS > LFSR_WIDTH || OUT_BITS == 0) begin : g_bad_width
            $error("masked_rand_source: OUT_BITS must be in 1..64");
        end
    endgenerate

    rand_state_t           state_reg, state_next;
    logic [LFSR_WIDTH-1:0] lfsr_reg, lfsr_next, lfsr_stepped;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic                  seed_ready_reg;
    logic                  seed_accept;

    lfsr_unrolled #(
        .STEPS(OUT_BITS)
    ) u_step (
        .in_state (lfsr_reg),
        .out_state(lfsr_stepped)
    );

    assign seed_accept    = in_seed_valid & seed_ready_reg;
    assign out_seed_ready = seed_ready_reg;
    assign out_valid      = (state_reg == RS_RUN);
    assign out_r          = lfsr_reg[HALF-1:0];
    assign out_p          = lfsr_reg[OUT_BITS-1:HALF];

`ifdef RAND_SOURCE_HEALTH_EN
    logic error_reg, error_next;
    assign out_error = error_reg;
`else
    assign out_error = 1'b0;
`endif

    // Controller registers; reset returns everything to the idle, zeroed state.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_reg      <= RS_IDLE;
            lfsr_reg       <= '0;
            cnt_reg        <= '0;
            seed_ready_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lfsr_reg       <= lfsr_next;
            cnt_reg        <= cnt_next;
            seed_ready_reg <= 1'b1;
        end
    end

`ifdef RAND_SOURCE_HEALTH_EN
    // Sticky fault flag; only reset clears it.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            error_reg <= 1'b0;
        end else begin
            error_reg <= error_next;
        end
    end
`endif

    // Next-state: warm-up steps unconditionally, RUN steps per transfer,
    // a zero state faults back to IDLE, and a seed accept overrides all.
    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        cnt_next   = cnt_reg;
`ifdef RAND_SOURCE_HEALTH_EN
        error_next = error_reg;
`endif
        case (state_reg)
            RS_IDLE: begin
            end
            RS_WARMUP: begin
                lfsr_next = lfsr_stepped;
                cnt_next  = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = RS_RUN;
                end
            end
            RS_RUN: begin
                if (in_ready) begin
                    lfsr_next = lfsr_stepped;
                end
            end
            default: begin
                state_next = RS_IDLE;
            end
        endcase
`ifdef RAND_SOURCE_HEALTH_EN
        if (state_reg != RS_IDLE && lfsr_reg == '0) begin
            error_next = 1'b1;
            state_next = RS_IDLE;
        end
`endif
        if (seed_accept) begin
            lfsr_next  = (in_seed == '0) ? {{(LFSR_WIDTH-1){1'b0}}, 1'b1} : in_seed;
            cnt_next   = CW'(WARMUP_CYCLES);
            state_next = (WARMUP_CYCLES == 0) ? RS_RUN : RS_WARMUP;
        end
    end

endmodule

// File: tb/tb_masked_rand_source.sv
// Self-checking bench for masked_rand_source: a W=0 and a W=16 instance,
// directed steps plus random seeds and random in_ready against a
// bit-serial software LFSR model. Define RAND_SOURCE_HEALTH_EN to add the
// zero-state fault scenario.
module tb_masked_rand_source;

    logic clk;
    logic rst;

    // Instance with default warm-up (16)
    logic [63:0] seed_a;
    logic        seed_valid_a, seed_ready_a, ready_a, valid_a, error_a;
    logic [1:0]  r_a, p_a;

    // Instance with zero warm-up
    logic [63:0] seed_z;
    logic        seed_valid_z, seed_ready_z, ready_z, valid_z, error_z;
    logic [1:0]  r_z, p_z;

    int tests;
    int fails;

    masked_rand_source dut (
        .in_clock      (clk),
        .in_reset      (rst),
        .in_seed       (seed_a),
        .in_seed_valid (seed_valid_a),
        .out_seed_ready(seed_ready_a),
        .out_r         (r_a),
        .out_p         (p_a),
        .out_valid     (valid_a),
        .in_ready      (ready_a),
        .out_error     (error_a)
    );

    masked_rand_source #(.WARMUP_CYCLES(0)) dut0 (
        .in_clock      (clk),
        .in_reset      (rst),
        .in_seed       (seed_z),
        .in_seed_valid (seed_valid_z),
        .out_seed_ready(seed_ready_z),
        .out_r         (r_z),
        .out_p         (p_z),
        .out_valid     (valid_z),
        .in_ready      (ready_z),
        .out_error     (error_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: n single steps of the Fibonacci LFSR, taps 63,62,60,59.
    function automatic logic [63:0] lfsr_adv(input logic [63:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
        end
        return s;
    endfunction

    function automatic logic [63:0] seed_load(input logic [63:0] s);
        return (s == 64'h0) ? 64'h1 : s;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] m;
    logic [63:0] s_rand;
    logic        rdy;

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        seed_a = '0; seed_valid_a = 1'b0; ready_a = 1'b0;
        seed_z = '0; seed_valid_z = 1'b0; ready_z = 1'b0;

        // Reset state
        #1;
        check("rst_valid",      {63'd0, valid_a},      64'd0);
        check("rst_seed_ready", {63'd0, seed_ready_a}, 64'd0);
        check("rst_word",       {60'd0, p_a, r_a},     64'd0);
        check("rst_error",      {63'd0, error_a},      64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("seed_ready_a", {63'd0, seed_ready_a}, 64'd1);
        check("seed_ready_z", {63'd0, seed_ready_z}, 64'd1);
        check("idle_valid",   {63'd0, valid_a},      64'd0);

        // Scenario 1: W=0, seed 1
        seed_z = 64'h1; seed_valid_z = 1'b1;
        tick();
        seed_valid_z = 1'b0;
        check("s1_valid", {63'd0, valid_z}, 64'd1);
        check("s1_r",     {62'd0, r_z},     64'd1);
        check("s1_p",     {62'd0, p_z},     64'd0);
        m = 64'h1;
        for (int i = 0; i < 3; i++) begin
            ready_z = 1'b1;
            tick();
            ready_z = 1'b0;
            m = lfsr_adv(m, 4);
            check("s1_xfer_word",  {60'd0, p_z, r_z}, {60'd0, m[3:0]});
            check("s1_xfer_valid", {63'd0, valid_z},  64'd1);
        end

        // Scenario 2: zero seed loads as 1
        seed_z = 64'h0; seed_valid_z = 1'b1;
        tick();
        seed_valid_z = 1'b0;
        check("s2_valid", {63'd0, valid_z},  64'd1);
        check("s2_word",  {60'd0, p_z, r_z}, 64'h1);
        ready_z = 1'b1;
        tick();
        ready_z = 1'b0;
        check("s2_next_word", {60'd0, p_z, r_z}, 64'h0);

        // Scenario 3: W=16, random seed
        s_rand = {$urandom, $urandom};
        seed_a = s_rand; seed_valid_a = 1'b1;
        tick();
        seed_valid_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("s3_warmup_valid", {63'd0, valid_a}, 64'd0);
            tick();
        end
        m = lfsr_adv(seed_load(s_rand), 16 * 4);
        check("s3_valid", {63'd0, valid_a},  64'd1);
        check("s3_word",  {60'd0, p_a, r_a}, {60'd0, m[3:0]});

        // Scenario 4: hold, then consecutive transfers, then random in_ready
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s4_hold_word", {60'd0, p_a, r_a}, {60'd0, m[3:0]});
        end
        ready_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            m = lfsr_adv(m, 4);
            check("s4_xfer_word", {60'd0, p_a, r_a}, {60'd0, m[3:0]});
        end
        for (int i = 0; i < 30; i++) begin
            rdy = 1'($urandom_range(0, 1));
            ready_a = rdy;
            tick();
            if (rdy) m = lfsr_adv(m, 4);
            check("s4_rand_word",  {60'd0, p_a, r_a}, {60'd0, m[3:0]});
            check("s4_rand_valid", {63'd0, valid_a},  64'd1);
        end

        // Scenario 5: reseed in RUN with in_ready high
        ready_a = 1'b1;
        s_rand = {$urandom, $urandom};
        seed_a = s_rand; seed_valid_a = 1'b1;
        tick();
        seed_valid_a = 1'b0;
        check("s5_reseed_valid", {63'd0, valid_a}, 64'd0);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("s5_warmup_valid", {63'd0, valid_a}, 64'd0);
        end
        ready_a = 1'b0;
        tick();
        m = lfsr_adv(seed_load(s_rand), 16 * 4);
        check("s5_valid", {63'd0, valid_a},  64'd1);
        check("s5_word",  {60'd0, p_a, r_a}, {60'd0, m[3:0]});
        check("s5_error", {63'd0, error_a},  64'd0);

`ifdef RAND_SOURCE_HEALTH_EN
        // Scenario 6: zero state in RUN faults, reseed recovers streaming
        force dut.lfsr_reg = 64'h0;
        tick();
        release dut.lfsr_reg;
        check("s6_error", {63'd0, error_a}, 64'd1);
        check("s6_valid", {63'd0, valid_a}, 64'd0);
        tick();
        check("s6_error_sticky", {63'd0, error_a}, 64'd1);
        s_rand = {$urandom, $urandom};
        seed_a = s_rand; seed_valid_a = 1'b1;
        tick();
        seed_valid_a = 1'b0;
        for (int i = 1; i < 17; i++) tick();
        m = lfsr_adv(seed_load(s_rand), 16 * 4);
        check("s6_resume_valid", {63'd0, valid_a},  64'd1);
        check("s6_resume_word",  {60'd0, p_a, r_a}, {60'd0, m[3:0]});
        check("s6_resume_error", {63'd0, error_a},  64'd1);
`endif

        // Async reset mid-WARMUP: outputs clear without a clock edge
        seed_a = 64'hDEAD_BEEF_0123_4567; seed_valid_a = 1'b1;
        tick();
        seed_valid_a = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("areset_valid",      {63'd0, valid_a},      64'd0);
        check("areset_word",       {60'd0, p_a, r_a},     64'd0);
        check("areset_seed_ready", {63'd0, seed_ready_a}, 64'd0);
        check("areset_error",      {63'd0, error_a},      64'd0);
        check("areset_valid_z",    {63'd0, valid_z},      64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_ready", {63'd0, seed_ready_a}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
